// File: rtl/param_regfile_if.sv
// rtl/param_regfile_if.sv - write port and packed read ports of the parametrised register file
interface param_regfile_if #(
  parameter int WIDTH    = 64,
  parameter int AW       = 5,
  parameter int NUM_READ = 2
);
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [NUM_READ*AW-1:0]    rd_addr;
  logic [NUM_READ*WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - NUM_REGS x WIDTH register file, one write port, NUM_READ combinational read ports
module param_regfile #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 0
) (
  input logic            clk,
  input logic            reset,
  param_regfile_if.slave bus
);
  localparam int AW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  logic [WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]       we;
  logic                      wr_qual;
  logic [NUM_READ*WIDTH-1:0] rd_flat;

  // A write only counts when it lands on a real, writable register outside reset.
  always_comb begin
    wr_qual = bus.wr_en && !reset && (int'(bus.wr_addr) < NUM_REGS) &&
              !((ZERO_EN != 0) && (int'(bus.wr_addr) == ZERO_IDX));
    we = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      we[r] = wr_qual && (int'(bus.wr_addr) == r);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) begin
        regs[r] <= '0;
      end else if (we[r]) begin
        regs[r] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    rd_flat = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      ra = bus.rd_addr[p*AW +: AW];
      if ((int'(ra) < NUM_REGS) && !((ZERO_EN != 0) && (int'(ra) == ZERO_IDX))) begin
        rd_flat[p*WIDTH +: WIDTH] = regs[ra];
        // wr_qual already excludes reset, the zero register and out-of-range targets
        if ((BYPASS != 0) && wr_qual && (ra == bus.wr_addr)) begin
          rd_flat[p*WIDTH +: WIDTH] = bus.wr_data;
        end
      end
    end
  end

  assign bus.rd_data = rd_flat;
endmodule

// File: doc/param_regfile.md
# param_regfile

Parametrised multi-port register file built from banks of enabled registers. It is the generalised successor to the single enabled register: NUM_REGS words of WIDTH bits, one synchronous write port, NUM_READ independent combinational read ports, an optional hardwired-zero register, and an optional write-to-read bypass. In the LEGv8 datapath it serves as the integer register file (default 32 x 64, X31 reads zero, two read ports).

## Interface
- WIDTH, 64, data width of every register and of every read/write data bus
- NUM_REGS, 32, number of addressable registers; need not be a power of two
- NUM_READ, 2, number of read ports (1..8)
- ZERO_EN, 1, when 1, register ZERO_IDX is hardwired to 0
- ZERO_IDX, 31, index of the hardwired-zero register; ignored when ZERO_EN=0
- BYPASS, 0, when 1, a read of the address being written this cycle returns wr_data
- Derived: AW = max(1, $clog2(NUM_REGS))

- clk  input  1  single clock; all state changes on posedge clk
- reset  input  1  synchronous, active-high; clears every register at the next posedge
- wr_en  input  1  write enable for the write port
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_addr  input  NUM_READ*AW  packed read addresses; port p uses bits [p*AW +: AW]
- rd_data  output  NUM_READ*WIDTH  packed read data; port p drives bits [p*WIDTH +: WIDTH]

## Operation
- Storage: NUM_REGS registers, each with enable; only one register's enable asserted per cycle (decoded from wr_addr).
- Write qualifies when wr_en=1, reset=0, wr_addr < NUM_REGS, and not (ZERO_EN=1 and wr_addr=ZERO_IDX). Unqualified writes leave all state unchanged.
- Reset priority: reset=1 overrides wr_en; all registers become 0 at that posedge.
- Read port p: rd_data[p] = 0 if rd_addr[p] >= NUM_REGS, or ZERO_EN=1 and rd_addr[p]=ZERO_IDX; otherwise stored value of register rd_addr[p].
- Bypass (BYPASS=1 only): if the write is qualified this cycle and rd_addr[p]=wr_addr, rd_data[p]=wr_data. Bypass never applies to the zero register, out-of-range addresses, or during reset.
- Multiple read ports may address the same register simultaneously; all see identical data.
- No read-side state: read ports are purely combinational from addresses and stored contents.

## Timing
- Write latency: value written at posedge N is visible on any read port immediately after posedge N (BYPASS=0); with BYPASS=1 it is visible combinationally during cycle N before the edge.
- Read latency: combinational, zero cycles from rd_addr change.
- Reset: after one posedge with reset=1, every register reads 0; outputs for in-range addresses are 0 from then until a qualified write. Reset asserted mid-sequence discards any write presented in the same cycle.
- Before first reset, register contents are undefined (X in simulation); benches reset first.
- Write and read of same address same cycle, BYPASS=0: read returns old value until the edge.

## Test plan
- Reset with wr_en=1, wr_addr=5, wr_data=64'hFFFF for 2 cycles -> all 32 registers read 0 on both ports.
- Write register i with value {i, i+1...} pattern 64'h0101_0101_0101_0101*i for i=0..30, then read all pairs (i, 30-i) -> each port returns its written value; X31 always 0.
- Write 64'hDEAD_BEEF to index 31 -> both ports reading 31 return 0; register 30 unchanged.
- wr_en=0 with wr_addr=7, wr_data=64'h1234 over 4 cycles -> register 7 keeps prior value 64'h0707_0707_0707_0707.
- BYPASS=1 instance: same cycle wr_en=1, wr_addr=3, wr_data=64'hABCD, rd_addr0=3 -> rd_data0=64'hABCD before the edge; BYPASS=0 instance returns old value until posedge.
- NUM_REGS=20, NUM_READ=3, WIDTH=16, ZERO_EN=0: write to addr 25 ignored, read of addr 25 returns 0; writes to addr 19 read back 16'h5A5A on all three ports simultaneously.
